// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module : digit_serial_adder
// Multi-cycle WIDTH-bit add/subtract engine, DIGIT bits per clock.
// It has a start/done handshake and registered carry, overflow and zero flags.
// Rev    : 1.0
// ============================================================================
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int            N      = WIDTH / DIGIT;
  localparam int            CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("digit_serial_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_v;
  logic             r_z;

  logic [DIGIT:0]   w_dsum;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_acc_next;

  assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_carry};

  // Carry into the top bit of the digit, recovered from its sum and operand bits.
  assign w_msb_cin = w_dsum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];

  generate
    if (N == 1) begin : g_single_digit
      assign w_acc_next = w_dsum[DIGIT-1:0];
    end else begin : g_multi_digit
      assign w_acc_next = {w_dsum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == C_LAST) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= Sub ? ~B : B;
        r_carry <= Sub ? ~Cin : Cin;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_acc   <= w_acc_next;
        r_carry <= w_dsum[DIGIT];
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_s    <= w_acc_next;
          r_cout <= w_dsum[DIGIT];
          r_v    <= w_msb_cin ^ w_dsum[DIGIT];
          r_z    <= (w_acc_next == '0);
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign S    = r_s;
  assign Cout = r_cout;
  assign V    = r_v;
  assign Z    = r_z;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// Bench for digit_serial_adder: four configurations (8/1, 8/2, 16/4, 8/8) run
// fixed vectors, handshake corner sequences and random operations against an arithmetic model.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic [3:0]  cin_v;
  logic [3:0]  sub_v;
  logic [15:0] a_v [4];
  logic [15:0] b_v [4];
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  cout_v;
  logic [3:0]  ov_v;
  logic [3:0]  z_v;
  logic [15:0] s_v [4];
  logic [7:0]  s0, s1, s3;
  logic [15:0] s2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0][7:0]), .B(b_v[0][7:0]),
    .Cin(cin_v[0]), .Sub(sub_v[0]), .busy(busy_v[0]), .done(done_v[0]), .S(s0),
    .Cout(cout_v[0]), .V(ov_v[0]), .Z(z_v[0]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1][7:0]), .B(b_v[1][7:0]),
    .Cin(cin_v[1]), .Sub(sub_v[1]), .busy(busy_v[1]), .done(done_v[1]), .S(s1),
    .Cout(cout_v[1]), .V(ov_v[1]), .Z(z_v[1]));
  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]),
    .Cin(cin_v[2]), .Sub(sub_v[2]), .busy(busy_v[2]), .done(done_v[2]), .S(s2),
    .Cout(cout_v[2]), .V(ov_v[2]), .Z(z_v[2]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .A(a_v[3][7:0]), .B(b_v[3][7:0]),
    .Cin(cin_v[3]), .Sub(sub_v[3]), .busy(busy_v[3]), .done(done_v[3]), .S(s3),
    .Cout(cout_v[3]), .V(ov_v[3]), .Z(z_v[3]));

  assign s_v[0] = {8'h00, s0};
  assign s_v[1] = {8'h00, s1};
  assign s_v[2] = s2;
  assign s_v[3] = {8'h00, s3};

  function automatic int wid(input int u);
    return (u == 2) ? 16 : 8;
  endfunction

  function automatic int ndig(input int u);
    case (u)
      0:       return 8;
      1:       return 4;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: the whole operation as one integer sum, flags from operand/result signs.
  task automatic model(input int u, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, output logic [15:0] s,
                       output logic co, output logic ov, output logic zz);
    int unsigned w, m, bb, tot, sa, sb, ss;
    w   = wid(u);
    m   = (32'd1 << w) - 1;
    bb  = sub ? (~{16'h0, b} & m) : ({16'h0, b} & m);
    tot = ({16'h0, a} & m) + bb + ((sub ? !cin : cin) ? 1 : 0);
    s   = 16'(tot & m);
    co  = tot[w];
    sa  = ({16'h0, a} >> (w - 1)) & 1;
    sb  = (bb >> (w - 1)) & 1;
    ss  = (tot >> (w - 1)) & 1;
    ov  = (sa == sb) && (ss != sa);
    zz  = (s == 16'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    a_v[u]   = a;
    b_v[u]   = b;
    cin_v[u] = cin;
    sub_v[u] = sub;
  endtask

  task automatic wait_done(input int u, output int lat);
    lat = 0;
    while (!done_v[u] && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Single start pulse, then wait for done; returns edges from acceptance to done.
  task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, output int lat);
    drive(u, a, b, cin, sub);
    start_v[u] = 1'b1;
    tick();
    start_v[u] = 1'b0;
    check($sformatf("busy_after_accept_u%0d", u), busy_v[u], 1'b1);
    wait_done(u, lat);
  endtask

  task automatic check_result(input string tag, input int u, input logic [15:0] es,
                              input logic ec, input logic ev, input logic ez);
    check({tag, "_S"},    s_v[u],    es);
    check({tag, "_Cout"}, cout_v[u], ec);
    check({tag, "_V"},    ov_v[u],   ev);
    check({tag, "_Z"},    z_v[u],    ez);
  endtask

  typedef struct {
    int          u;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          dcount;
    logic [15:0] es;
    logic        ec, ev, ez;

    vecs[0] = '{0, 16'd10,   16'd15,   1'b0, 1'b0, 16'd25,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 16'd255,  16'd1,    1'b0, 1'b0, 16'd0,    1'b1, 1'b0, 1'b1};
    vecs[2] = '{0, 16'd1,    16'd255,  1'b0, 1'b0, 16'd0,    1'b1, 1'b0, 1'b1};
    vecs[3] = '{0, 16'd127,  16'd1,    1'b0, 1'b0, 16'd128,  1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 16'd5,    16'd7,    1'b0, 1'b1, 16'hFE,   1'b0, 1'b0, 1'b0};
    vecs[5] = '{1, 16'd7,    16'd5,    1'b0, 1'b1, 16'd2,    1'b1, 1'b0, 1'b0};
    vecs[6] = '{1, 16'h80,   16'd1,    1'b0, 1'b1, 16'h7F,   1'b1, 1'b1, 1'b0};
    vecs[7] = '{2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{3, 16'd100,  16'd100,  1'b1, 1'b0, 16'hC9,   1'b0, 1'b1, 1'b0};
    vecs[9] = '{3, 16'd3,    16'd3,    1'b0, 1'b1, 16'h00,   1'b1, 1'b0, 1'b1};

    start_v = '0;
    for (int u = 0; u < 4; u++) drive(u, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int u = 0; u < 4; u++) begin
      check($sformatf("reset_busy_u%0d", u), busy_v[u], 1'b0);
      check($sformatf("reset_done_u%0d", u), done_v[u], 1'b0);
      check_result($sformatf("reset_u%0d", u), u, 16'h0, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].u, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), lat, ndig(vecs[i].u));
      check($sformatf("vec%0d_busy_at_done", i), busy_v[vecs[i].u], 1'b0);
      check_result($sformatf("vec%0d", i), vecs[i].u, vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z);
      tick();
      check($sformatf("vec%0d_done_one_cycle", i), done_v[vecs[i].u], 1'b0);
      check($sformatf("vec%0d_S_hold", i), s_v[vecs[i].u], vecs[i].s);
    end

    // Back-to-back on 16/4: start held through done; second op accepted in the done cycle.
    drive(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    start_v[2] = 1'b1;
    tick();
    drive(2, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
    wait_done(2, lat);
    check("b2b_first_latency", lat, 4);
    check_result("b2b_first", 2, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    start_v[2] = 1'b0;
    check("b2b_second_accepted", busy_v[2], 1'b1);
    check("b2b_first_S_hold", s_v[2], 16'h0000);
    wait_done(2, lat);
    check("b2b_second_gap", lat + 1, 5);
    check_result("b2b_second", 2, 16'h2144, 1'b0, 1'b0, 1'b0);

    // start during RUN is ignored and yields exactly one done.
    drive(0, 16'd10, 16'd15, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    tick();
    drive(0, 16'd99, 16'd1, 1'b1, 1'b1);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_done(0, lat);
    check("ignore_latency", lat + 4, 8);
    check_result("ignore", 0, 16'd25, 1'b0, 1'b0, 1'b0);
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done_v[0]) dcount++;
    end
    check("ignore_no_extra_done", dcount, 0);

    // Reset mid-operation aborts it without a done.
    drive(0, 16'd3, 16'd4, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy_v[0], 1'b0);
    check("abort_done", done_v[0], 1'b0);
    check_result("abort", 0, 16'h0, 1'b0, 1'b0, 1'b0);
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done_v[0]) dcount++;
    end
    check("abort_no_done", dcount, 0);

    // Random operations against the arithmetic model.
    for (int u = 0; u < 4; u++) begin
      for (int t = 0; t < 40; t++) begin
        logic [15:0] ra, rb;
        logic        rc, rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (wid(u) == 8) begin
          ra[15:8] = 8'h00;
          rb[15:8] = 8'h00;
        end
        rc = 1'($urandom);
        rs = 1'($urandom);
        model(u, ra, rb, rc, rs, es, ec, ev, ez);
        run_op(u, ra, rb, rc, rs, lat);
        check($sformatf("rnd_u%0d_t%0d_latency", u, t), lat, ndig(u));
        check_result($sformatf("rnd_u%0d_t%0d", u, t), u, es, ec, ev, ez);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parameterised, multi-cycle add/subtract unit for the EMU datapath ALU. It generalises the combinational 8-bit full adder into a WIDTH-bit engine that processes DIGIT bits per clock. This trades latency for area. The unit has a start/done handshake, subtract mode, and registered status flags (carry, overflow, zero) for the flags register.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2.
DIGIT, 1, bits processed per clock; WIDTH must be an integer multiple of DIGIT. A violation is an elaboration error.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when busy=0
A  input  WIDTH  operand A, sampled on the accepting edge
B  input  WIDTH  operand B, sampled on the accepting edge
Cin  input  1  carry-in (add) / borrow-in (subtract), sampled on the accepting edge
Sub  input  1  0 = add, 1 = subtract, sampled on the accepting edge
busy  output  1  operation in progress
done  output  1  one-cycle pulse: S and flags just updated
S  output  WIDTH  registered result
Cout  output  1  carry-out (add) / not-borrow (subtract)
V  output  1  two's-complement overflow
Z  output  1  S == 0

Behaviour:
- Reset (rst=1 at an edge): FSM to IDLE; busy=0, done=0, S=0, Cout=0, V=0, Z=0; internal registers cleared. Reset overrides start and aborts any in-flight operation. No done is produced for an aborted operation.
- N = WIDTH/DIGIT.
- States: IDLE, RUN.
  - IDLE: start=1 at edge k accepts the operation.
    - Latch A and B' (B' = Sub ? ~B : B).
    - Latch carry c0 = Sub ? ~Cin : Cin.
    - Clear digit counter; go to RUN; busy=1 from after edge k.
  - RUN: at each edge, add the lowest DIGIT bits of A and B' plus the carry register.
    - Shift the DIGIT sum bits into the top of the result shift register.
    - Shift the operand registers right by DIGIT.
    - Update the carry register; increment the counter.
  - RUN, edge k+N (last digit): load S from the completed shift register.
    - Load Cout = final carry.
    - Load V = carry into MSB XOR carry out of MSB. With DIGIT>1 the MSB carry is taken from inside the last digit.
    - Load Z = (final S == 0).
    - Pulse done=1 for exactly one cycle; busy=0; return to IDLE.
- Arithmetic:
  - Add: {Cout,S} = A + B + Cin.
  - Subtract: {Cout,S} = A + ~B + ~Cin = A − B − Cin mod 2^WIDTH. Here Cout=1 means no borrow.
- Latency: done asserts N cycles after the accepting edge. Back-to-back throughput is one operation per N+1 cycles.
- start while busy=1: ignored, with no effect on state or outputs. start is not queued.
- start in the same cycle as done (busy=0): accepted. Outputs from the completed operation remain valid for at least that cycle.
- Outputs S, Cout, V, Z hold their values from done until the next done or reset. They never show partial results during RUN.
- Operand inputs are don't-care except on the accepting edge; changes during RUN have no effect.
- N=1 (DIGIT=WIDTH): valid. The result appears one edge after acceptance.

Test Plan:
1. WIDTH=8, DIGIT=1, A=10, B=15, Cin=0, Sub=0, start pulse -> busy high for 8 cycles; done pulses once 8 cycles after acceptance; S=25, Cout=0, V=0, Z=0.
2. WIDTH=8, DIGIT=1:
   - A=255, B=1 add -> S=0, Cout=1, V=0, Z=1.
   - Then A=1, B=255 -> identical result.
   - Then A=127, B=1 -> S=128, Cout=0, V=1, Z=0.
3. WIDTH=8, DIGIT=2, Sub=1, Cin=0:
   - A=5, B=7 -> done after 4 cycles; S=0xFE, Cout=0, V=0, Z=0.
   - Then A=7, B=5 -> S=2, Cout=1.
   - Then A=0x80, B=1 -> S=0x7F, V=1.
4. WIDTH=16, DIGIT=4, A=0xFFFF, B=0x0001, Cin=0 add -> done 4 cycles after start; S=0, Cout=1, Z=1.
   - Back-to-back start held high through done -> second op accepted in done cycle; second done 5 cycles after first.
5. WIDTH=8, DIGIT=1, start A=10, B=15:
   - Change A/B and pulse start during RUN -> ignored; S=25 on single done.
   - New op A=3, B=4, then assert rst on its 3rd RUN cycle -> no done; busy=0, S=0, Cout=V=Z=0 next cycle.
